// File: rtl/uart_rx_framed.sv
// UART receiver with input synchroniser, mid-bit sampling, false-start rejection,
// optional parity, 1/2 stop bits, per-frame parity/framing flags and break handling.
`timescale 1ns/1ps
module uart_rx_framed #(
  parameter int CLK_BAUD_RATIO = 100,
  parameter int DATA_SIZE      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 new_data_out,
  output logic                 busy_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out
);

  localparam int HALF  = CLK_BAUD_RATIO / 2;
  localparam int CNT_W = $clog2(CLK_BAUD_RATIO);
  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   new_q, new_d;
  logic                   busy_q, busy_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  logic rxs;
  logic baud_tick;
  logic frame_bad;
  logic par_calc;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign baud_tick = (cnt_q == CNT_W'(CLK_BAUD_RATIO - 1));
  assign par_calc  = (^shift_q) ^ par_bit_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_in};
    prev_d     = rxs;
    data_d     = data_q;
    new_d      = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_bad  = ferr_acc_q | ~rxs;

    case (state_q)
      S_IDLE: begin
        // prev_q resets low, so a line held low out of reset never looks like a start.
        if (prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DATA;
            bit_d      = '0;
            ferr_acc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          if (bit_q == BIT_W'(DATA_SIZE - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          cnt_d     = '0;
          par_bit_d = rxs;
          state_d   = S_STOP;
          stop_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          cnt_d = '0;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            data_d  = shift_q;
            ferr_d  = frame_bad;
            perr_d  = (PARITY == 1) ? ~par_calc : (PARITY == 2) ? par_calc : 1'b0;
            new_d   = 1'b1;
            state_d = frame_bad ? S_BREAK : S_IDLE;
          end else begin
            stop_d     = 1'b1;
            ferr_acc_d = frame_bad;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Leaving only once the line is high means the next start needs a fresh edge.
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      data_q     <= '0;
      new_q      <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      data_q     <= data_d;
      new_q      <= new_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out       = data_q;
  assign new_data_out   = new_q;
  assign busy_out       = busy_q;
  assign parity_err_out = perr_q;
  assign frame_err_out  = ferr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: three instances (no parity, even parity, two stop bits)
// driven by directed frames; a negedge monitor pops expected words on each new_data_out.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam int R = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx    [3];
  logic [3:0] dout  [3];
  logic       nd    [3];
  logic       busy  [3];
  logic       perr  [3];
  logic       ferr  [3];
  logic       nd_prev [3];

  typedef struct {
    int         inst;
    logic [3:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  uart_rx_framed #(.CLK_BAUD_RATIO(R), .DATA_SIZE(4), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_p0 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx[0]), .data_out(dout[0]), .new_data_out(nd[0]),
    .busy_out(busy[0]), .parity_err_out(perr[0]), .frame_err_out(ferr[0]));

  uart_rx_framed #(.CLK_BAUD_RATIO(R), .DATA_SIZE(4), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_p2 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx[1]), .data_out(dout[1]), .new_data_out(nd[1]),
    .busy_out(busy[1]), .parity_err_out(perr[1]), .frame_err_out(ferr[1]));

  uart_rx_framed #(.CLK_BAUD_RATIO(R), .DATA_SIZE(4), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_s2 (
    .clk_in(clk), .rst_in(rst), .rx_in(rx[2]), .data_out(dout[2]), .new_data_out(nd[2]),
    .busy_out(busy[2]), .parity_err_out(perr[2]), .frame_err_out(ferr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every delivered word against the head of the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        nd_prev[i] <= 1'b0;
      end else begin
        if (nd[i]) begin
          check("pulse_gap", 32'(nd_prev[i]), 0);
          check("pulse_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("pulse_inst", i, mon_e.inst);
            check("data_out", 32'(dout[i]), 32'(mon_e.data));
            check("parity_err", 32'(perr[i]), 32'(mon_e.perr));
            check("frame_err", 32'(ferr[i]), 32'(mon_e.ferr));
          end
        end
        nd_prev[i] <= nd[i];
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int i, input logic b);
    rx[i] = b;
    hold(R);
  endtask

  task automatic send_frame(input int i, input logic [3:0] d, input bit has_par,
                            input logic par_bit, input int nstop, input logic stop_val);
    send_bit(i, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(i, d[k]);
    if (has_par) send_bit(i, par_bit);
    for (int s = 0; s < nstop; s++) send_bit(i, stop_val);
  endtask

  task automatic expect_word(input int i, input logic [3:0] d, input logic pe, input logic fe);
    exp_t e;
    e.inst = i;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(4);

    for (int i = 0; i < 3; i++) begin
      check("rst_data", 32'(dout[i]), 0);
      check("rst_new", 32'(nd[i]), 0);
      check("rst_busy", 32'(busy[i]), 0);
      check("rst_perr", 32'(perr[i]), 0);
      check("rst_ferr", 32'(ferr[i]), 0);
    end

    // Plain frame, no parity.
    expect_word(0, 4'b0110, 1'b0, 1'b0);
    send_frame(0, 4'b0110, 1'b0, 1'b0, 1, 1'b1);
    hold(10);
    check("t1_busy_idle", 32'(busy[0]), 0);

    // Even parity: good parity bit, then a bad one.
    expect_word(1, 4'b0110, 1'b0, 1'b0);
    send_frame(1, 4'b0110, 1'b1, 1'b0, 1, 1'b1);
    hold(10);
    expect_word(1, 4'b0110, 1'b1, 1'b0);
    send_frame(1, 4'b0110, 1'b1, 1'b1, 1, 1'b1);
    hold(10);

    // Break: stop bit low and the line held low for 20 cycles.
    expect_word(0, 4'b1010, 1'b0, 1'b1);
    send_frame(0, 4'b1010, 1'b0, 1'b0, 1, 1'b0);
    hold(15);
    check("t3_busy_break", 32'(busy[0]), 1);
    rx[0] = 1'b1;
    hold(6);
    check("t3_busy_release", 32'(busy[0]), 0);
    hold(10);

    // False start: one cycle low.
    rx[0] = 1'b0;
    hold(1);
    rx[0] = 1'b1;
    hold(2);
    check("t4_busy_start", 32'(busy[0]), 1);
    hold(10);
    check("t4_busy_idle", 32'(busy[0]), 0);

    // Back-to-back frames with two stop bits.
    expect_word(2, 4'b1001, 1'b0, 1'b0);
    expect_word(2, 4'b0110, 1'b0, 1'b0);
    send_frame(2, 4'b1001, 1'b0, 1'b0, 2, 1'b1);
    send_frame(2, 4'b0110, 1'b0, 1'b0, 2, 1'b1);
    hold(10);

    // Reset mid-data-bit with the line left low afterwards.
    send_bit(0, 1'b0);
    rx[0] = 1'b0;
    hold(2);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(1);
    check("t6_rst_data", 32'(dout[0]), 0);
    check("t6_rst_ferr", 32'(ferr[0]), 0);
    check("t6_rst_busy", 32'(busy[0]), 0);
    check("t6_rst_new", 32'(nd[0]), 0);
    hold(40);
    check("t6_low_busy", 32'(busy[0]), 0);
    rx[0] = 1'b1;
    hold(10);
    expect_word(0, 4'b0011, 1'b0, 1'b0);
    send_frame(0, 4'b0011, 1'b0, 1'b0, 1, 1'b1);
    hold(10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
